// File: rtl/qpsk_bit_source.sv
// Symbol-rate bit source for the QPSK transmit path: symbol strobe generator plus
// independent I/Q Fibonacci LFSRs and deterministic test patterns.
module qpsk_bit_source #(
  parameter int          OS         = 4,
  parameter int          PRBS_ORDER = 9,
  parameter logic [14:0] SEED_I     = 15'h01FF,
  parameter logic [14:0] SEED_Q     = 15'h00AA,
  parameter int          CNT_W      = 32
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  output logic             o_strobe,
  output logic             o_bit_i,
  output logic             o_bit_q,
  output logic [CNT_W-1:0] o_sym_count
);

  localparam int N   = (PRBS_ORDER == 7) ? 7 : (PRBS_ORDER == 15) ? 15 : 9;
  localparam int TAP = (N == 7) ? 5 : (N == 15) ? 13 : 4;
  localparam int PW  = $clog2(OS);
  localparam logic [PW-1:0] LAST = PW'(OS - 1);

  // An all-zero seed would lock the LFSR, so it is replaced with all-ones.
  function automatic logic [N-1:0] fix_seed(input logic [14:0] s);
    fix_seed = (s[N-1:0] == '0) ? '1 : s[N-1:0];
  endfunction

  localparam logic [N-1:0] INIT_I = fix_seed(SEED_I);
  localparam logic [N-1:0] INIT_Q = fix_seed(SEED_Q);

  logic [PW-1:0]    r_cnt;
  logic [N-1:0]     r_lfsr_i;
  logic [N-1:0]     r_lfsr_q;
  logic             r_alt;
  logic             r_strobe;
  logic             r_bit_i;
  logic             r_bit_q;
  logic [CNT_W-1:0] r_sym_count;

  logic w_last;
  logic w_fb_i;
  logic w_fb_q;
  logic w_bit_i;
  logic w_bit_q;

  assign w_last = (r_cnt == LAST);
  assign w_fb_i = r_lfsr_i[N-1] ^ r_lfsr_i[TAP];
  assign w_fb_q = r_lfsr_q[N-1] ^ r_lfsr_q[TAP];

  always_comb begin
    w_bit_i = 1'b0;
    w_bit_q = 1'b0;
    case (i_mode)
      2'b00: begin
        w_bit_i = r_lfsr_i[N-1];
        w_bit_q = r_lfsr_q[N-1];
      end
      2'b10: begin
        w_bit_i = ~r_alt;
        w_bit_q = r_alt;
      end
      2'b11: begin
        w_bit_i = 1'b1;
        w_bit_q = 1'b1;
      end
      default: begin
        w_bit_i = 1'b0;
        w_bit_q = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_cnt       <= '0;
      r_lfsr_i    <= INIT_I;
      r_lfsr_q    <= INIT_Q;
      r_alt       <= 1'b0;
      r_strobe    <= 1'b0;
      r_bit_i     <= 1'b0;
      r_bit_q     <= 1'b0;
      r_sym_count <= '0;
    end else if (i_enable) begin
      if (w_last) begin
        // LFSRs advance in every mode so PRBS phase survives mode changes.
        r_cnt       <= '0;
        r_strobe    <= 1'b1;
        r_lfsr_i    <= {r_lfsr_i[N-2:0], w_fb_i};
        r_lfsr_q    <= {r_lfsr_q[N-2:0], w_fb_q};
        r_alt       <= ~r_alt;
        r_bit_i     <= w_bit_i;
        r_bit_q     <= w_bit_q;
        r_sym_count <= r_sym_count + CNT_W'(1);
      end else begin
        r_cnt    <= r_cnt + PW'(1);
        r_strobe <= 1'b0;
      end
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign o_strobe    = r_strobe;
  assign o_bit_i     = r_bit_i;
  assign o_bit_q     = r_bit_q;
  assign o_sym_count = r_sym_count;

endmodule

// File: tb/tb_qpsk_bit_source.sv
// Bench for qpsk_bit_source: three parameterisations driven in lockstep and checked
// against a symbol-index reference model, constant vectors and corner-case sequences.
module tb_qpsk_bit_source;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;

  logic        a_st, a_bi, a_bq;
  logic [31:0] a_cnt;
  logic        b_st, b_bi, b_bq;
  logic [31:0] b_cnt;
  logic        c_st, c_bi, c_bq;
  logic [3:0]  c_cnt;

  qpsk_bit_source #(.OS(4), .PRBS_ORDER(9), .SEED_I(15'h01FF), .SEED_Q(15'h00AA), .CNT_W(32)) dut_a (
    .CLK100MHZ(clk), .reset(reset), .i_enable(en), .i_mode(mode),
    .o_strobe(a_st), .o_bit_i(a_bi), .o_bit_q(a_bq), .o_sym_count(a_cnt));
  qpsk_bit_source #(.OS(3), .PRBS_ORDER(7), .SEED_I(15'h0000), .SEED_Q(15'h007F), .CNT_W(32)) dut_b (
    .CLK100MHZ(clk), .reset(reset), .i_enable(en), .i_mode(mode),
    .o_strobe(b_st), .o_bit_i(b_bi), .o_bit_q(b_bq), .o_sym_count(b_cnt));
  qpsk_bit_source #(.OS(5), .PRBS_ORDER(15), .SEED_I(15'h4ACE), .SEED_Q(15'h0000), .CNT_W(4)) dut_c (
    .CLK100MHZ(clk), .reset(reset), .i_enable(en), .i_mode(mode),
    .o_strobe(c_st), .o_bit_i(c_bi), .o_bit_q(c_bq), .o_sym_count(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: per DUT, enabled-edge phase and strobe index k select bits.
  int     os_p [3] = '{4, 3, 5};
  int     n_p  [3] = '{9, 7, 15};
  int     cw_p [3] = '{32, 32, 4};
  int     per  [3];
  bit     seq_i [3][32768];
  bit     seq_q [3][32768];
  int     ph   [3];
  longint k    [3];
  bit     m_st [3];
  bit     m_bi [3];
  bit     m_bq [3];

  typedef struct {
    logic [1:0] mode;
    bit         exp_i;
    bit         exp_q;
  } vec_t;
  vec_t tbl [16];

  task automatic gen(input int d, input int si, input int sq);
    int n, tap, mask, s, t, fb;
    n    = n_p[d];
    tap  = (n == 7) ? 5 : (n == 15) ? 13 : 4;
    mask = (1 << n) - 1;
    per[d] = mask;
    for (int c = 0; c < 2; c++) begin
      s = ((c == 0) ? si : sq) & mask;
      if (s == 0) s = mask;
      for (int j = 0; j < per[d]; j++) begin
        t = (s >> (n - 1)) & 1;
        if (c == 0) seq_i[d][j] = t[0]; else seq_q[d][j] = t[0];
        fb = t ^ ((s >> tap) & 1);
        s  = ((s << 1) | fb) & mask;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        ph[d] = 0; k[d] = 0; m_st[d] = 0; m_bi[d] = 0; m_bq[d] = 0;
      end else if (en) begin
        if (ph[d] == os_p[d] - 1) begin
          ph[d] = 0;
          k[d]++;
          m_st[d] = 1;
          case (mode)
            2'b00: begin
              m_bi[d] = seq_i[d][int'((k[d] - 1) % per[d])];
              m_bq[d] = seq_q[d][int'((k[d] - 1) % per[d])];
            end
            2'b01: begin m_bi[d] = 0; m_bq[d] = 0; end
            2'b10: begin m_bi[d] = (k[d] % 2 == 1); m_bq[d] = (k[d] % 2 == 0); end
            default: begin m_bi[d] = 1; m_bq[d] = 1; end
          endcase
        end else begin
          ph[d]++;
          m_st[d] = 0;
        end
      end else begin
        m_st[d] = 0;
      end
    end
  endtask

  task automatic check(input string nm, input int d, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  task automatic tick();
    longint m;
    @(posedge clk);
    model_step();
    @(negedge clk);
    m = (64'd1 << 32) - 1;
    check("model_strobe", 0, a_st, m_st[0]);
    check("model_bit_i",  0, a_bi, m_bi[0]);
    check("model_bit_q",  0, a_bq, m_bq[0]);
    check("model_count",  0, a_cnt, k[0] & m);
    check("model_strobe", 1, b_st, m_st[1]);
    check("model_bit_i",  1, b_bi, m_bi[1]);
    check("model_bit_q",  1, b_bq, m_bq[1]);
    check("model_count",  1, b_cnt, k[1] & m);
    check("model_strobe", 2, c_st, m_st[2]);
    check("model_bit_i",  2, c_bi, m_bi[2]);
    check("model_bit_q",  2, c_bq, m_bq[2]);
    check("model_count",  2, c_cnt, k[2] & ((64'd1 << cw_p[2]) - 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  bit b_exp [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    gen(0, 32'h1FF, 32'h0AA);
    gen(1, 32'h000, 32'h07F);
    gen(2, 32'h4ACE, 32'h0000);
    for (int d = 0; d < 3; d++) begin
      ph[d] = 0; k[d] = 0; m_st[d] = 0; m_bi[d] = 0; m_bq[d] = 0;
    end
    // First 16 strobes of dut_a; PRBS entries are the hand-expanded x^9+x^5+1 sequence.
    tbl = '{
      '{2'b00, 1, 0}, '{2'b10, 0, 1}, '{2'b01, 0, 0}, '{2'b11, 1, 1},
      '{2'b00, 1, 0}, '{2'b10, 0, 1}, '{2'b00, 1, 0}, '{2'b00, 1, 1},
      '{2'b00, 1, 0}, '{2'b00, 0, 0}, '{2'b10, 1, 0}, '{2'b00, 0, 0},
      '{2'b11, 1, 1}, '{2'b00, 0, 0}, '{2'b00, 1, 1}, '{2'b00, 1, 0}};

    en = 1'b0; mode = 2'b00; reset = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_strobe", 0, a_st, 0);
    check("reset_bits",   0, {a_bi, a_bq}, 0);
    check("reset_count",  0, a_cnt, 0);

    en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      mode = tbl[v].mode;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (c < 3) check("tbl_no_strobe", 0, a_st, 0);
      end
      check("tbl_strobe", 0, a_st, 1);
      check("tbl_bit_i",  0, a_bi, tbl[v].exp_i);
      check("tbl_bit_q",  0, a_bq, tbl[v].exp_q);
    end

    mode = 2'b00;
    for (int s = 17; s <= 521; s++) begin
      for (int c = 0; c < 4; c++) tick();
      if (s >= 512) check("period_511_bit_i", 0, a_bi, (s == 521) ? 0 : 1);
    end
    check("count_521", 0, a_cnt, 521);

    // Zero seed on order 7 must behave as seed 7F.
    do_reset();
    mode = 2'b00; en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 3; c++) tick();
      check("zero_seed_bit_i", 1, b_bi, b_exp[s]);
      check("zero_seed_bit_q", 1, b_bq, b_exp[s]);
    end

    // Enable gap: partial count survives the disabled stretch.
    do_reset();
    en = 1'b1; tick(); tick();
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("gap_no_strobe", 0, a_st, 0);
      check("gap_count",     0, a_cnt, 0);
    end
    en = 1'b1;
    tick(); check("reenable_1", 0, a_st, 0);
    tick(); check("reenable_2", 0, a_st, 1);
    check("reenable_bits", 0, {a_bi, a_bq}, 2'b10);

    // Alternating pattern then a mid-symbol switch back to PRBS.
    do_reset();
    mode = 2'b10; en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) tick();
      check("alt_bits", 0, {a_bi, a_bq}, (s == 1) ? 2'b01 : 2'b10);
    end
    tick();
    mode = 2'b00;
    tick(); tick(); tick();
    check("alt_to_prbs_strobe", 0, a_st, 1);
    check("alt_to_prbs_bits",   0, {a_bi, a_bq}, 2'b11);

    // Reset mid-symbol after 37 strobes, with cnt at 2.
    do_reset();
    mode = 2'b00; en = 1'b1;
    for (int c = 0; c < 37 * 4 + 2; c++) tick();
    check("pre_reset_count", 0, a_cnt, 37);
    do_reset();
    check("midreset_count",  0, a_cnt, 0);
    check("midreset_bits",   0, {a_bi, a_bq}, 0);
    check("midreset_strobe", 0, a_st, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_reset_strobe", 0, a_st, (c == 3) ? 1 : 0);
    end
    check("post_reset_seed_msb", 0, {a_bi, a_bq}, 2'b10);

    // 4-bit symbol counter wrap on dut_c (OS=5).
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 79; c++) tick();
    check("wrap_pre", 2, c_cnt, 15);
    tick();
    check("wrap_count",  2, c_cnt, 0);
    check("wrap_strobe", 2, c_st, 1);

    // Randomised enable/mode/reset traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 6) == 0) mode = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
